// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: branch func3 encodings and the redirect controller states.
package riscv_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } b_type_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } redir_state_t;

endpackage

// File: rtl/branch_control.sv
// Branch comparator: decides the conditional-branch direction from func3 and the two operands.
module branch_control
  import riscv_pkg::*;
(
  input  logic [31:0] opr_a_i,
  input  logic [31:0] opr_b_i,
  input  logic [2:0]  func3_i,
  input  logic        is_b_type_ctl_i,
  output logic        taken_o
);

  logic signed [31:0] opr_a_s;
  logic signed [31:0] opr_b_s;

  assign opr_a_s = opr_a_i;
  assign opr_b_s = opr_b_i;

  // Reserved func3 encodings (010/011) resolve as not taken.
  always_comb begin
    taken_o = 1'b0;
    if (is_b_type_ctl_i) begin
      case (b_type_t'(func3_i))
        BEQ:     taken_o = (opr_a_i == opr_b_i);
        BNE:     taken_o = (opr_a_i != opr_b_i);
        BLT:     taken_o = (opr_a_s <  opr_b_s);
        BGE:     taken_o = (opr_a_s >= opr_b_s);
        BLTU:    taken_o = (opr_a_i <  opr_b_i);
        BGEU:    taken_o = (opr_a_i >= opr_b_i);
        default: taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch resolution: mispredict redirect handshake, IF/ID squash window,
// branch-history update pulse and saturating branch/mispredict statistics.
module branch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid_i,
  input  logic [31:0]      ex_pc_i,
  input  logic             ex_is_b_type_i,
  input  logic             ex_is_jump_i,
  input  logic [2:0]       ex_func3_i,
  input  logic [31:0]      ex_opr_a_i,
  input  logic [31:0]      ex_opr_b_i,
  input  logic [31:0]      ex_target_i,
  input  logic             ex_pred_taken_i,
  input  logic [31:0]      ex_pred_target_i,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             ex_stall_o,
  output logic             bht_upd_valid_o,
  output logic [31:0]      bht_upd_pc_o,
  output logic             bht_upd_taken_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);

  localparam int FCW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  redir_state_t     state_q, state_d;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             bht_valid_q, bht_valid_d;
  logic [31:0]      bht_pc_q, bht_pc_d;
  logic             bht_taken_q, bht_taken_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic        cmp_taken;
  logic        resolve;
  logic        actual_taken;
  logic [31:0] pc_plus4;
  logic [31:0] correct_pc;
  logic [31:0] pred_pc;
  logic        mispredict;

  branch_control u_branch_control (
    .opr_a_i         (ex_opr_a_i),
    .opr_b_i         (ex_opr_b_i),
    .func3_i         (ex_func3_i),
    .is_b_type_ctl_i (ex_is_b_type_i),
    .taken_o         (cmp_taken)
  );

  // Instructions arriving outside IDLE are wrong-path and never resolve.
  assign resolve      = ex_valid_i & (ex_is_b_type_i | ex_is_jump_i) & (state_q == IDLE);
  assign actual_taken = ex_is_jump_i | (ex_is_b_type_i & cmp_taken);
  assign pc_plus4     = ex_pc_i + 32'd4;
  assign correct_pc   = actual_taken    ? ex_target_i      : pc_plus4;
  assign pred_pc      = ex_pred_taken_i ? ex_pred_target_i : pc_plus4;
  assign mispredict   = resolve & (correct_pc != pred_pc);

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d       = REDIRECT;
          redirect_pc_d = correct_pc;
        end
      end
      REDIRECT: begin
        if (redirect_ready_i) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d     = FLUSH;
            flush_cnt_d = FCW'(FLUSH_CYCLES);
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= FCW'(1)) begin
          state_d = IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bht_valid_d   = resolve & ex_is_b_type_i;
    bht_pc_d      = bht_pc_q;
    bht_taken_d   = bht_taken_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bht_valid_d) begin
      bht_pc_d    = ex_pc_i;
      bht_taken_d = actual_taken;
    end
    if (resolve && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      flush_cnt_q   <= '0;
      redirect_pc_q <= '0;
      bht_valid_q   <= 1'b0;
      bht_pc_q      <= '0;
      bht_taken_q   <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      bht_valid_q   <= bht_valid_d;
      bht_pc_q      <= bht_pc_d;
      bht_taken_q   <= bht_taken_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign redirect_valid_o = (state_q == REDIRECT);
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_if_o       = (state_q != IDLE);
  assign flush_id_o       = (state_q != IDLE);
  assign ex_stall_o       = (state_q != IDLE);
  assign bht_upd_valid_o  = bht_valid_q;
  assign bht_upd_pc_o     = bht_pc_q;
  assign bht_upd_taken_o  = bht_taken_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: one instance with a 2-cycle squash and 16-bit
// counters, a second with no squash window and 4-bit counters.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        reset;
  logic        reset_z;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_is_b_type_i;
  logic        ex_is_jump_i;
  logic [2:0]  ex_func3_i;
  logic [31:0] ex_opr_a_i;
  logic [31:0] ex_opr_b_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        redirect_ready_i;

  logic        redirect_valid_o, flush_if_o, flush_id_o, ex_stall_o;
  logic [31:0] redirect_pc_o, bht_upd_pc_o;
  logic        bht_upd_valid_o, bht_upd_taken_o;
  logic [15:0] branch_cnt_o, mispredict_cnt_o;

  logic        redirect_valid_z, flush_if_z, flush_id_z, ex_stall_z;
  logic [31:0] redirect_pc_z, bht_upd_pc_z;
  logic        bht_upd_valid_z, bht_upd_taken_z;
  logic [3:0]  branch_cnt_z, mispredict_cnt_z;

  int n_checks;
  int n_pass;

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .ex_is_b_type_i(ex_is_b_type_i), .ex_is_jump_i(ex_is_jump_i), .ex_func3_i(ex_func3_i),
    .ex_opr_a_i(ex_opr_a_i), .ex_opr_b_i(ex_opr_b_i), .ex_target_i(ex_target_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i), .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
    .ex_stall_o(ex_stall_o), .bht_upd_valid_o(bht_upd_valid_o), .bht_upd_pc_o(bht_upd_pc_o),
    .bht_upd_taken_o(bht_upd_taken_o), .branch_cnt_o(branch_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_W(4)) dut_z (
    .clk(clk), .reset(reset_z), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .ex_is_b_type_i(ex_is_b_type_i), .ex_is_jump_i(ex_is_jump_i), .ex_func3_i(ex_func3_i),
    .ex_opr_a_i(ex_opr_a_i), .ex_opr_b_i(ex_opr_b_i), .ex_target_i(ex_target_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .redirect_valid_o(redirect_valid_z), .redirect_pc_o(redirect_pc_z),
    .redirect_ready_i(redirect_ready_i), .flush_if_o(flush_if_z), .flush_id_o(flush_id_z),
    .ex_stall_o(ex_stall_z), .bht_upd_valid_o(bht_upd_valid_z), .bht_upd_pc_o(bht_upd_pc_z),
    .bht_upd_taken_o(bht_upd_taken_z), .branch_cnt_o(branch_cnt_z),
    .mispredict_cnt_o(mispredict_cnt_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic b, input logic j, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] bb, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    ex_valid_i       = 1'b1;
    ex_is_b_type_i   = b;
    ex_is_jump_i     = j;
    ex_func3_i       = f3;
    ex_opr_a_i       = a;
    ex_opr_b_i       = bb;
    ex_pc_i          = pc;
    ex_target_i      = tgt;
    ex_pred_taken_i  = pt;
    ex_pred_target_i = ptgt;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    reset_z = 1'b1;
    redirect_ready_i = 1'b0;
    set_br(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    ex_valid_i = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_rv", redirect_valid_o, 0);
    chk("rst_pc", redirect_pc_o, 0);
    chk("rst_flush", {flush_if_o, flush_id_o}, 0);
    chk("rst_stall", ex_stall_o, 0);
    chk("rst_bht", {bht_upd_valid_o, bht_upd_taken_o, bht_upd_pc_o}, 0);
    chk("rst_cnt", {branch_cnt_o, mispredict_cnt_o}, 0);
    reset = 1'b0;

    // BEQ correctly predicted taken
    set_br(1'b1, 1'b0, 3'b000, 32'd5, 32'd5, 32'h10, 32'h100, 1'b1, 32'h100);
    tick();
    ex_valid_i = 1'b0;
    chk("beq_rv", redirect_valid_o, 0);
    chk("beq_stall", ex_stall_o, 0);
    chk("beq_bht_v", bht_upd_valid_o, 1);
    chk("beq_bht_t", bht_upd_taken_o, 1);
    chk("beq_bht_pc", bht_upd_pc_o, 32'h10);
    chk("beq_bcnt", branch_cnt_o, 1);
    chk("beq_mcnt", mispredict_cnt_o, 0);

    // BLT -1 < 1 predicted not-taken: redirect to 0x80
    set_br(1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h80, 1'b0, 32'h0);
    tick();
    ex_valid_i = 1'b0;
    chk("blt_rv", redirect_valid_o, 1);
    chk("blt_pc", redirect_pc_o, 32'h80);
    chk("blt_flush", {flush_if_o, flush_id_o}, 2'b11);
    chk("blt_stall", ex_stall_o, 1);
    chk("blt_bht_t", {bht_upd_valid_o, bht_upd_taken_o}, 2'b11);
    chk("blt_mcnt", mispredict_cnt_o, 1);
    chk("blt_bcnt", branch_cnt_o, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("blt_hold_rv", redirect_valid_o, 1);
      chk("blt_hold_pc", redirect_pc_o, 32'h80);
      if (i == 0) chk("blt_bht_pulse", bht_upd_valid_o, 0);
    end
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    chk("blt_f1_rv", redirect_valid_o, 0);
    chk("blt_f1_flush", {flush_if_o, flush_id_o, ex_stall_o}, 3'b111);
    tick();
    chk("blt_f2_flush", {flush_if_o, flush_id_o, ex_stall_o}, 3'b111);
    tick();
    chk("blt_idle", {flush_if_o, flush_id_o, ex_stall_o}, 3'b000);
    chk("blt_mcnt2", mispredict_cnt_o, 1);

    // BNE not taken, predicted taken at top of address space: pc+4 wraps to 0
    set_br(1'b1, 1'b0, 3'b001, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h100, 1'b1, 32'h100);
    tick();
    ex_valid_i = 1'b0;
    redirect_ready_i = 1'b1;
    chk("bne_rv", redirect_valid_o, 1);
    chk("bne_pc", redirect_pc_o, 32'h0);
    chk("bne_bht_t", {bht_upd_valid_o, bht_upd_taken_o}, 2'b10);
    tick();
    redirect_ready_i = 1'b0;
    tick();
    tick();
    chk("bne_idle", ex_stall_o, 0);
    chk("bne_cnt", {branch_cnt_o, mispredict_cnt_o}, {16'd3, 16'd2});

    // JAL predicted not-taken; wrong-path BEQ held valid during REDIRECT/FLUSH
    set_br(1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 32'h300, 32'h200, 1'b0, 32'h0);
    tick();
    chk("jal_rv", redirect_valid_o, 1);
    chk("jal_pc", redirect_pc_o, 32'h200);
    chk("jal_no_bht", bht_upd_valid_o, 0);
    chk("jal_cnt", {branch_cnt_o, mispredict_cnt_o}, {16'd4, 16'd3});
    set_br(1'b1, 1'b0, 3'b000, 32'd1, 32'd1, 32'h500, 32'h600, 1'b1, 32'h600);
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    chk("jal_f1_bht", bht_upd_valid_o, 0);
    tick();
    ex_valid_i = 1'b0;
    chk("jal_f2_flush", flush_if_o, 1);
    chk("jal_f2_bht", bht_upd_valid_o, 0);
    tick();
    chk("jal_ignored_cnt", {branch_cnt_o, mispredict_cnt_o}, {16'd4, 16'd3});
    chk("jal_idle", ex_stall_o, 0);

    // Reset asserted in the second REDIRECT cycle, with ready high in that cycle
    set_br(1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h80, 1'b0, 32'h0);
    tick();
    ex_valid_i = 1'b0;
    tick();
    chk("rr_pre_rv", redirect_valid_o, 1);
    reset = 1'b1;
    redirect_ready_i = 1'b1;
    tick();
    reset = 1'b0;
    redirect_ready_i = 1'b0;
    chk("rr_outs", {redirect_valid_o, flush_if_o, flush_id_o, ex_stall_o}, 0);
    chk("rr_pc", redirect_pc_o, 0);
    chk("rr_bht", {bht_upd_valid_o, bht_upd_taken_o, bht_upd_pc_o}, 0);
    chk("rr_cnt", {branch_cnt_o, mispredict_cnt_o}, 0);
    tick();
    chk("rr_idle", {redirect_valid_o, ex_stall_o}, 0);

    // Back-to-back correct branches, then saturation of branch_cnt
    set_br(1'b1, 1'b0, 3'b000, 32'd5, 32'd5, 32'h10, 32'h100, 1'b1, 32'h100);
    tick();
    chk("b2b_stall", ex_stall_o, 0);
    tick();
    chk("b2b_cnt", branch_cnt_o, 2);
    repeat (65537) tick();
    ex_valid_i = 1'b0;
    chk("sat_bcnt", branch_cnt_o, 16'hFFFF);
    chk("sat_mcnt", mispredict_cnt_o, 0);
    chk("sat_stall", ex_stall_o, 0);

    // Zero-length squash instance
    reset = 1'b1;
    reset_z = 1'b0;
    set_br(1'b1, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h80, 1'b0, 32'h0);
    tick();
    ex_valid_i = 1'b0;
    redirect_ready_i = 1'b1;
    chk("z_rv", redirect_valid_z, 1);
    chk("z_pc", redirect_pc_z, 32'h80);
    tick();
    chk("z_idle", {redirect_valid_z, flush_if_z, flush_id_z, ex_stall_z}, 0);
    chk("z_cnt", {branch_cnt_z, mispredict_cnt_z}, {4'd1, 4'd1});
    ex_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tick();
    end
    ex_valid_i = 1'b0;
    redirect_ready_i = 1'b0;
    chk("z_sat_m", mispredict_cnt_z, 4'hF);
    chk("z_sat_b", branch_cnt_z, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Execute-stage branch resolution controller for the RISC-V core. It evaluates each resolved branch or jump against the fetch-stage prediction. On a mispredict it drives a redirect PC to fetch through a valid/ready handshake, then squashes the IF/ID stages for a programmable number of cycles. It also emits branch-history update pulses and keeps saturating branch and mispredict statistics.

## Interface
- FLUSH_CYCLES, 2: number of cycles the younger-stage squash is held after fetch accepts the redirect (0 is legal).
- CNT_W, 16: width of the statistics counters.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset. One clock; all state is updated on the rising edge of clk.
- ex_valid_i  in  1  EX stage holds a valid instruction this cycle.
- ex_pc_i  in  32  PC of the EX instruction.
- ex_is_b_type_i  in  1  instruction is a conditional branch.
- ex_is_jump_i  in  1  instruction is JAL/JALR (always taken).
- ex_func3_i  in  3  branch func3.
- ex_opr_a_i, ex_opr_b_i  in  32  branch comparison operands.
- ex_target_i  in  32  computed taken target.
- ex_pred_taken_i  in  1  fetch predicted taken.
- ex_pred_target_i  in  32  fetch-predicted target.
- redirect_valid_o  out  1  redirect request to fetch.
- redirect_pc_o  out  32  corrected fetch PC.
- redirect_ready_i  in  1  fetch accepts the redirect.
- flush_if_o, flush_id_o  out  1  squash the IF and ID stages.
- ex_stall_o  out  1  hold EX; the controller is busy.
- bht_upd_valid_o  out  1  one-cycle history update pulse.
- bht_upd_pc_o  out  32  PC of the branch being updated.
- bht_upd_taken_o  out  1  resolved direction.
- branch_cnt_o, mispredict_cnt_o  out  CNT_W  saturating statistics counters.

## Operation
- Resolution occurs when ex_valid_i & (ex_is_b_type_i | ex_is_jump_i) & state==IDLE.
- actual_taken = ex_is_jump_i | (ex_is_b_type_i & taken). "taken" comes from the comparator sub-module driven by ex_opr_a_i, ex_opr_b_i and ex_func3_i; is_b_type_ctl_i is tied to ex_is_b_type_i.
- correct_pc = actual_taken ? ex_target_i : ex_pc_i+4.
- pred_pc = ex_pred_taken_i ? ex_pred_target_i : ex_pc_i+4.
- All additions are 32-bit and wrap modulo 2^32.
- A resolution is a mispredict when correct_pc != pred_pc.
- FSM states and transitions:
  - IDLE -> REDIRECT on a mispredicting resolution. correct_pc is latched into redirect_pc_o.
  - REDIRECT -> FLUSH on redirect_valid_o & redirect_ready_i. The counter is loaded with FLUSH_CYCLES. If FLUSH_CYCLES==0, the transition goes directly to IDLE.
  - FLUSH: the counter decrements each cycle. FLUSH -> IDLE when the counter reaches 1.
- Outputs by state:
  - redirect_valid_o = (state==REDIRECT).
  - flush_if_o = flush_id_o = (state!=IDLE).
  - ex_stall_o = (state!=IDLE).
- redirect_pc_o holds stable while redirect_valid_o is high and redirect_ready_i is low.
- ex_valid_i is ignored outside IDLE, since it is wrong-path. Ignored instructions produce no counts and no BHT update.
- The BHT update is registered and pulses for every resolved b-type instruction in IDLE, regardless of mispredict. Jumps do not update the BHT.
- branch_cnt_o increments on every resolution. mispredict_cnt_o increments on every mispredict. Both saturate at all-ones.

## Timing
- Reset: state=IDLE, counters 0, every output 0 (redirect_pc_o=0, bht_upd_*=0).
- A reset asserted mid-REDIRECT or mid-FLUSH drops every output to 0 on the next edge. No handshake completes in a reset cycle.
- Mispredict resolved in cycle N: redirect_valid_o, flush_*_o and ex_stall_o are high from N+1. bht_upd_valid_o pulses at N+1.
- With redirect_ready_i high in cycle M: flush stays high through M+FLUSH_CYCLES, and IDLE begins at M+FLUSH_CYCLES+1, where a new resolution is accepted.
- A correctly predicted resolution causes no stall and no flush. Back-to-back correct resolutions are accepted every cycle.

## Structure
- Shared package riscv_pkg holds the b_type_t func3 enum (BEQ/BNE/BLT/BGE/BLTU/BGEU) and the redirect FSM state enum (IDLE, REDIRECT, FLUSH).
- One sub-module: branch_control (the existing comparator), instantiated for "taken". No other hierarchy.

## Test plan
- BEQ with a=5, b=5, pred_taken=1, pred_target=ex_target=0x100. Required: no redirect, no stall, bht_upd_taken=1 next cycle, branch_cnt=1, mispredict_cnt=0.
- BLT with a=0xFFFFFFFF (-1), b=1, pred_taken=0, pc=0x40, target=0x80. Required: redirect_pc_o=0x80 at N+1; ready held low 3 cycles, during which redirect_pc_o stays stable; with FLUSH_CYCLES=2 flush is held for 2 cycles after the handshake; mispredict_cnt=1.
- BNE with a=b, pred_taken=1, pc=0xFFFFFFFC. Required: redirect_pc_o=0x00000000 (wrap).
- JAL with pred_taken=0, target=0x200. Required: redirect to 0x200; no BHT pulse; ex_valid_i pulses during FLUSH produce no counts.
- Assert reset in the second REDIRECT cycle. Required: all outputs 0 next cycle, state IDLE, counters 0.
- 2^CNT_W+3 correct branches. Required: branch_cnt_o saturates at 2^CNT_W-1. Repeat the mispredict sequence with FLUSH_CYCLES=0: IDLE directly after the handshake.
